fifo_frame_reader: RTL and testbench



---
 rtl/fifo_frame_reader_pkg.sv | 14 +
 rtl/fifo_frame_reader_out_buffer.sv | 62 ++++++
 rtl/fifo_frame_reader.sv | 158 +++++++++++++++
 tb/tb_fifo_frame_reader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_frame_reader_pkg.sv
// Shared definitions for the clk_fft-domain frame reader: sequencer states,
// output buffer depth and statistics counter width.
package fifo_frame_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PAD  = 2'd2
    } state_t;

    localparam int BUF_DEPTH = 3;
    localparam int STATS_W   = 32;

endpackage

// File: rtl/fifo_frame_reader_out_buffer.sv
// frame_out_buffer: 3-entry synchronous FIFO holding samples returned by the
// registered FIFO read, with per-entry last/user flags and exposed occupancy.
module frame_out_buffer
    import fifo_frame_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_push_last,
    input  logic                  i_push_user,
    input  logic                  i_pop,
    output logic [1:0]            o_occ,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_user
);

    logic [DATA_WIDTH-1:0] r_data [BUF_DEPTH];
    logic [BUF_DEPTH-1:0]  r_last;
    logic [BUF_DEPTH-1:0]  r_user;
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [1:0]            r_occ;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_data[r_wr_ptr] <= i_push_data;
            r_last[r_wr_ptr] <= i_push_last;
            r_user[r_wr_ptr] <= i_push_user;
        end
    end

    assign o_occ  = r_occ;
    assign o_data = r_data[r_rd_ptr];
    assign o_last = r_last[r_rd_ptr];
    assign o_user = r_user[r_rd_ptr];

endmodule

// File: rtl/fifo_frame_reader.sv
// Frame sequencer draining the sample FIFO into a valid/ready stream with last,
// padding with flagged zeros on underrun. Stats ports: FIFO_FRAME_READER_STATS_EN.
module fifo_frame_reader
    import fifo_frame_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 10,
    parameter int TIMEOUT    = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [LEN_W-1:0]      frame_len_m1,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tlast,
    output logic                  m_tuser,
    output logic                  busy,
    output logic                  underrun
`ifdef FIFO_FRAME_READER_STATS_EN
    ,
    output logic [STATS_W-1:0]    frame_count,
    output logic [STATS_W-1:0]    pad_count
`endif
);

    localparam int                 STALL_W   = $clog2(TIMEOUT) + 1;
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(TIMEOUT - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [LEN_W:0]       r_len_q;
    logic [LEN_W:0]       r_issue_cnt;
    logic [LEN_W:0]       r_out_cnt;
    logic [STALL_W-1:0]   r_stall_cnt;
    logic                 r_rd_vld_p1;
    logic                 r_rd_last_p1;

    logic [1:0]            w_occ;
    logic [DATA_WIDTH-1:0] w_buf_data;
    logic                  w_buf_last;
    logic                  w_buf_user;
    logic                  w_buf_vld;
    logic                  w_need;
    logic                  w_credit;
    logic                  w_stall;
    logic                  w_pad_beat;
    logic                  w_acc;
    logic                  w_pop;
    logic                  w_last_acc;
    logic                  w_restart;
    logic                  w_start;

    // Issue side: reads are credited against buffer space plus the read in flight.
    assign w_need     = (r_state == ST_RUN) && (r_issue_cnt <= r_len_q);
    assign w_credit   = (3'(w_occ) + 3'(r_rd_vld_p1)) < 3'(BUF_DEPTH);
    assign fifo_rd_en = w_need && w_credit && !fifo_rd_empty;
    assign w_stall    = w_need && fifo_rd_empty;
    assign underrun   = w_stall && (r_stall_cnt == STALL_LIM);

    // Output side: buffered samples always drain before any pad beat.
    assign w_buf_vld  = (w_occ != 2'd0);
    assign w_pad_beat = (r_state == ST_PAD) && !w_buf_vld && !r_rd_vld_p1;
    assign m_tvalid   = w_buf_vld || w_pad_beat;
    assign m_tdata    = w_buf_vld ? w_buf_data : '0;
    assign m_tuser    = w_buf_vld ? w_buf_user : w_pad_beat;
    assign m_tlast    = w_buf_vld ? w_buf_last : (w_pad_beat && (r_out_cnt == r_len_q));
    assign busy       = (r_state != ST_IDLE);

    assign w_acc      = m_tvalid && m_tready;
    assign w_pop      = w_acc && w_buf_vld;
    assign w_last_acc = w_acc && m_tlast;
    assign w_restart  = enable && !fifo_rd_empty;
    assign w_start    = ((r_state == ST_IDLE) || w_last_acc) && w_restart;

    frame_out_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_push      (r_rd_vld_p1),
        .i_push_data (fifo_rd_data),
        .i_push_last (r_rd_last_p1),
        .i_push_user (1'b0),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_data      (w_buf_data),
        .o_last      (w_buf_last),
        .o_user      (w_buf_user)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_restart) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_last_acc)    w_state_nxt = w_restart ? ST_RUN : ST_IDLE;
                else if (underrun) w_state_nxt = ST_PAD;
            end
            ST_PAD:  if (w_last_acc) w_state_nxt = w_restart ? ST_RUN : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // p1: read issued last cycle; its data lands in the buffer this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_len_q      <= '0;
            r_issue_cnt  <= '0;
            r_out_cnt    <= '0;
            r_stall_cnt  <= '0;
            r_rd_vld_p1  <= 1'b0;
            r_rd_last_p1 <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_vld_p1  <= fifo_rd_en;
            r_rd_last_p1 <= fifo_rd_en && (r_issue_cnt == r_len_q);
            if (w_start) begin
                r_len_q     <= {1'b0, frame_len_m1};
                r_issue_cnt <= '0;
                r_out_cnt   <= '0;
                r_stall_cnt <= '0;
            end else begin
                if (fifo_rd_en) begin
                    r_issue_cnt <= r_issue_cnt + 1'b1;
                    r_stall_cnt <= '0;
                end else if (w_stall) begin
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                end
                if (w_acc) r_out_cnt <= r_out_cnt + 1'b1;
            end
        end
    end

`ifdef FIFO_FRAME_READER_STATS_EN
    logic [STATS_W-1:0] r_frame_count;
    logic [STATS_W-1:0] r_pad_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_count <= '0;
            r_pad_count   <= '0;
        end else begin
            if (w_last_acc)          r_frame_count <= r_frame_count + 1'b1;
            if (w_acc && m_tuser)    r_pad_count   <= r_pad_count + 1'b1;
        end
    end

    assign frame_count = r_frame_count;
    assign pad_count   = r_pad_count;
`endif

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Scoreboard bench for fifo_frame_reader: a FIFO model feeds the DUT, stimulus
// queues expected beats, a monitor compares every accepted output beat.
module tb_fifo_frame_reader;

    localparam int DW = 8;
    localparam int LW = 10;
    localparam int TO = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic          u;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [LW-1:0] frame_len_m1 = '0;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_empty = 1'b1;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic          m_tuser;
    logic          busy;
    logic          underrun;
`ifdef FIFO_FRAME_READER_STATS_EN
    logic [31:0]   frame_count;
    logic [31:0]   pad_count;
`endif

    always #5 clk = ~clk;

    fifo_frame_reader #(
        .DATA_WIDTH (DW),
        .LEN_W      (LW),
        .TIMEOUT    (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .frame_len_m1  (frame_len_m1),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .m_tdata       (m_tdata),
        .m_tlast       (m_tlast),
        .m_tuser       (m_tuser),
        .busy          (busy),
        .underrun      (underrun)
`ifdef FIFO_FRAME_READER_STATS_EN
        ,
        .frame_count   (frame_count),
        .pad_count     (pad_count)
`endif
    );

    logic [DW-1:0] fmem [$];
    beat_t         exp_q [$];
    int n_tests = 0;
    int n_fail  = 0;
    int beats = 0, cyc = 0, credit = 0, credit_viol = 0, rd_empty_viol = 0;
    int ur_pulses = 0, ur_cyc = -1, last_rd_cyc = -1, rd_total = 0;
    logic  hold_vld = 1'b0;
    beat_t hold_beat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Registered-read FIFO model; pushes from stimulus show up on empty one edge later.
    always @(posedge clk) begin
        if (fifo_rd_en && fmem.size() != 0) fifo_rd_data <= fmem.pop_front();
        fifo_rd_empty <= (fmem.size() == 0);
    end

    // Monitor samples one time unit before each rising edge.
    initial forever begin
        beat_t e;
        @(negedge clk);
        #4;
        cyc++;
        if (rst) credit = 0;
        if (hold_vld)
            check("hold", 32'({m_tvalid, m_tdata, m_tlast, m_tuser}), 32'({1'b1, hold_beat}));
        hold_vld  = m_tvalid && !m_tready;
        hold_beat = {m_tdata, m_tlast, m_tuser};
        if (fifo_rd_en) begin
            if (credit >= 3)   credit_viol++;
            if (fifo_rd_empty) rd_empty_viol++;
            last_rd_cyc = cyc;
            rd_total++;
        end
        if (underrun) begin
            ur_pulses++;
            ur_cyc = cyc;
        end
        if (m_tvalid && m_tready) begin
            beats++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL extra_beat: got %0h expected none", {m_tdata, m_tlast, m_tuser});
            end else begin
                e = exp_q.pop_front();
                check("beat", 32'({m_tdata, m_tlast, m_tuser}), 32'(e));
            end
            if (!m_tuser) credit--;
        end
        if (fifo_rd_en) credit++;
    end

    task automatic push_samples(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) fmem.push_back(base + DW'(i));
    endtask

    // Expected beats of one frame: n_data FIFO samples then zero pads, last on beat len.
    task automatic exp_frame(input logic [DW-1:0] base, input int n_data, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = (i < n_data) ? base + DW'(i) : '0;
            b.l = (i == len - 1);
            b.u = (i >= n_data);
            exp_q.push_back(b);
        end
    endtask

    task automatic run(input int budget, input int drop_at, input bit toggle);
        int n = 0;
        while (n < budget && !(exp_q.size() == 0 && !busy)) begin
            @(negedge clk);
            n++;
            if (beats >= drop_at) enable = 1'b0;
            if (toggle) m_tready = !m_tready;
        end
        m_tready = 1'b1;
        n_tests++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d beats left expected 0", exp_q.size());
        end
    endtask

    initial begin
        int rd0, rd1, k;
`ifdef FIFO_FRAME_READER_STATS_EN
        logic [31:0] st0;
`endif
        repeat (3) @(negedge clk);
        check("rst_rd_en",    32'(fifo_rd_en), 0);
        check("rst_tvalid",   32'(m_tvalid),   0);
        check("rst_tlast",    32'(m_tlast),    0);
        check("rst_tuser",    32'(m_tuser),    0);
        check("rst_tdata",    32'(m_tdata),    0);
        check("rst_busy",     32'(busy),       0);
        check("rst_underrun", 32'(underrun),   0);
`ifdef FIFO_FRAME_READER_STATS_EN
        check("rst_stats", {frame_count[15:0], pad_count[15:0]}, 0);
`endif
        rst = 1'b0;

        // Length-4 frames back to back; enable drops during the second.
        push_samples(10, 8'h10);
        exp_frame(8'h10, 4, 4);
        exp_frame(8'h14, 4, 4);
        frame_len_m1 = 10'd3;
        @(negedge clk);
        enable = 1'b1;
        run(300, beats + 5, 1'b0);

        // One-sample frames consume the two leftovers plus two more.
        push_samples(2, 8'h70);
        exp_frame(8'h18, 1, 1);
        exp_frame(8'h19, 1, 1);
        exp_frame(8'h70, 1, 1);
        exp_frame(8'h71, 1, 1);
        frame_len_m1 = 10'd0;
        rd0 = rd_total;
`ifdef FIFO_FRAME_READER_STATS_EN
        st0 = frame_count;
`endif
        @(negedge clk);
        enable = 1'b1;
        run(300, 1 << 30, 1'b0);
        enable = 1'b0;
        check("min_reads", 32'(rd_total - rd0), 4);
`ifdef FIFO_FRAME_READER_STATS_EN
        check("min_frame_count", frame_count - st0, 4);
`endif

        // 16-sample frame with m_tready toggling every cycle.
        push_samples(16, 8'h40);
        exp_frame(8'h40, 16, 16);
        frame_len_m1 = 10'd15;
        @(negedge clk);
        enable = 1'b1;
        run(600, beats + 1, 1'b1);
        check("credit_viol", 32'(credit_viol), 0);

        // Underrun: 3 samples for an 8-beat frame.
        push_samples(3, 8'h60);
        exp_frame(8'h60, 3, 8);
        frame_len_m1 = 10'd7;
`ifdef FIFO_FRAME_READER_STATS_EN
        st0 = pad_count;
`endif
        @(negedge clk);
        enable = 1'b1;
        run(300, beats + 1, 1'b0);
        check("ur_pulses", 32'(ur_pulses), 1);
        check("ur_delay",  32'(ur_cyc - last_rd_cyc), TO);
`ifdef FIFO_FRAME_READER_STATS_EN
        check("pad_count", pad_count - st0, 5);
`endif

        // Reset while beat 5 of 16 is presented.
        push_samples(16, 8'h80);
        exp_frame(8'h80, 16, 16);
        frame_len_m1 = 10'd15;
        @(negedge clk);
        enable = 1'b1;
        rd0 = beats;
        k = 0;
        while (k < 300 && beats - rd0 < 4) begin
            @(negedge clk);
            k++;
            if (beats > rd0) enable = 1'b0;
        end
        check("mid_reached_beat5", 32'(beats - rd0), 4);
        rst = 1'b1;
        #1;
        check("mid_rst_outs",
              32'({m_tvalid, m_tdata, m_tlast, m_tuser, busy, fifo_rd_en, underrun}), 0);
        exp_q.delete();
        fmem.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_samples(4, 8'h90);
        exp_frame(8'h90, 4, 4);
        frame_len_m1 = 10'd3;
        @(negedge clk);
        enable = 1'b1;
        run(300, beats + 1, 1'b0);

        // Two frames queued; enable dropped during the first.
        push_samples(8, 8'hA0);
        exp_frame(8'hA0, 4, 4);
        frame_len_m1 = 10'd3;
        rd0 = rd_total;
        @(negedge clk);
        enable = 1'b1;
        run(300, beats + 1, 1'b0);
        check("en_drop_reads", 32'(rd_total - rd0), 4);
        check("en_drop_left",  32'(fmem.size()), 4);
        rd1 = rd_total;
        repeat (10) @(negedge clk);
        check("en_drop_no_rd", 32'(rd_total - rd1), 0);
        check("en_drop_busy",  32'(busy), 0);

        check("exp_empty",     32'(exp_q.size()), 0);
        check("rd_empty_viol", 32'(rd_empty_viol), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
